// File: rtl/imem_loadable_if.sv
// Bus bundle for imem_loadable: streaming program-load port plus the fetch port.
// The master side (loader/datapath) drives requests; the slave side is the memory.
interface imem_loadable_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_restart;
  logic [IDX_W:0]        load_count;
  logic                  loaded;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_instr;
  logic [1:0]            fetch_fault;

  modport master (
    output load_valid, load_data, load_last, load_restart, fetch_req, fetch_addr,
    input  load_ready, load_count, loaded, fetch_valid, fetch_instr, fetch_fault
  );

  modport slave (
    input  load_valid, load_data, load_last, load_restart, fetch_req, fetch_addr,
    output load_ready, load_count, loaded, fetch_valid, fetch_instr, fetch_fault
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory: LOAD/RUN sequencer, one-write/one-read word array,
// registered fetch with misalignment/out-of-range faults and NOP substitution.
module imem_loadable #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    IDX_W      = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'hD503201F
) (
  input  logic            clk,
  input  logic            reset,
  imem_loadable_if.slave  bus
);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t                state_reg;
  logic [IDX_W-1:0]      wptr_reg;
  logic [IDX_W:0]        count_reg;
  logic [DEPTH-1:0]      written_vec;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  use_nop_reg;
  logic                  fetch_valid_reg;
  logic [1:0]            fault_reg;

  logic             load_fire;
  logic             restart;
  logic             fetch_fire;
  logic             last_slot;
  logic             misaligned;
  logic             out_of_range;
  logic [IDX_W-1:0] fetch_idx;

  assign load_fire    = (state_reg == S_LOAD) && bus.load_valid;
  assign restart      = (state_reg == S_RUN) && bus.load_restart;
  assign fetch_fire   = (state_reg == S_RUN) && bus.fetch_req && !bus.load_restart;
  assign last_slot    = (wptr_reg == IDX_W'(DEPTH - 1));
  assign fetch_idx    = bus.fetch_addr[IDX_W+1:2];
  assign misaligned   = |bus.fetch_addr[1:0];
  // DEPTH is a power of two, so "word index >= DEPTH" is any set bit above the index field.
  assign out_of_range = |bus.fetch_addr[ADDR_WIDTH-1:IDX_W+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_LOAD;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else if (state_reg == S_LOAD) begin
      if (load_fire) begin
        wptr_reg  <= wptr_reg + 1'b1;
        count_reg <= count_reg + 1'b1;
        if (bus.load_last || last_slot) begin
          state_reg <= S_RUN;
        end
      end
    end else if (restart) begin
      state_reg <= S_LOAD;
      wptr_reg  <= '0;
      count_reg <= '0;
    end
  end

  // Per-word written flags mask stale array contents left over from earlier programs.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_written
      logic written_reg;
      always_ff @(posedge clk) begin
        if (reset || restart) begin
          written_reg <= 1'b0;
        end else if (load_fire && (wptr_reg == IDX_W'(gi))) begin
          written_reg <= 1'b1;
        end
      end
      assign written_vec[gi] = written_reg;
    end
  endgenerate

  // Array write and read kept free of reset so the storage maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wptr_reg] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      rd_data_reg <= mem[fetch_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_reg <= 1'b0;
      use_nop_reg     <= 1'b1;
      fault_reg       <= 2'b00;
    end else begin
      fetch_valid_reg <= fetch_fire;
      if (fetch_fire) begin
        fault_reg   <= {out_of_range, misaligned};
        use_nop_reg <= out_of_range || misaligned || !written_vec[fetch_idx];
      end
    end
  end

  assign bus.load_ready  = (state_reg == S_LOAD);
  assign bus.loaded      = (state_reg == S_RUN);
  assign bus.load_count  = count_reg;
  assign bus.fetch_valid = fetch_valid_reg;
  assign bus.fetch_fault = fault_reg;
  assign bus.fetch_instr = use_nop_reg ? NOP_WORD : rd_data_reg;

endmodule

// File: tb/tb_imem_loadable.sv
// Randomised self-checking bench for imem_loadable against an array/flag reference model.
module tb_imem_loadable;
  localparam int          AW    = 64;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam int          IDX_W = 6;
  localparam logic [31:0] NOP   = 32'hD503201F;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  imem_loadable_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_W(IDX_W)) bus ();

  imem_loadable #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_W(IDX_W), .NOP_WORD(NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: program words, written flags, accepted count, run flag.
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          m_count;
  bit          m_run;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    m_count = 0;
    m_run   = 1'b0;
  endtask

  function automatic logic [1:0] exp_fault(logic [63:0] a);
    return {((a >> 2) >= 64'(DEPTH)), (a[1:0] != 2'b00)};
  endfunction

  function automatic logic [31:0] exp_instr(logic [63:0] a);
    if (exp_fault(a) != 2'b00) return NOP;
    if (!m_wr[int'(a >> 2)]) return NOP;
    return m_mem[int'(a >> 2)];
  endfunction

  task automatic idle_inputs();
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.load_last    = 1'b0;
    bus.load_restart = 1'b0;
    bus.fetch_req    = 1'b0;
    bus.fetch_addr   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic load_cycle(input bit valid, input logic [31:0] d, input bit last);
    bus.load_valid = valid;
    bus.load_data  = d;
    bus.load_last  = last;
    cycle();
    if (valid && !m_run) begin
      m_mem[m_count] = d;
      m_wr[m_count]  = 1'b1;
      m_count++;
      if (last || m_count == DEPTH) m_run = 1'b1;
      $display("[TB] load word=%h last=%0d count=%0d", d, last, m_count);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic fetch_issue(input bit req, input logic [63:0] a);
    bus.fetch_req  = req;
    bus.fetch_addr = a;
    cycle();
    bus.fetch_req  = 1'b0;
    if (req) $display("[TB] fetch addr=%h instr=%h fault=%b valid=%b",
                      a, bus.fetch_instr, bus.fetch_fault, bus.fetch_valid);
  endtask

  task automatic test_reset();
    do_reset();
    if (bus.fetch_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", bus.fetch_valid); tests_failed++; end
    if (bus.fetch_instr !== NOP) begin $display("FAIL rst_instr: got %h want %h", bus.fetch_instr, NOP); tests_failed++; end
    if (bus.fetch_fault !== 2'b00) begin $display("FAIL rst_fault: got %b want 00", bus.fetch_fault); tests_failed++; end
    if (bus.loaded !== 1'b0) begin $display("FAIL rst_loaded: got %b want 0", bus.loaded); tests_failed++; end
    if (bus.load_count !== 7'd0) begin $display("FAIL rst_count: got %0d want 0", bus.load_count); tests_failed++; end
    if (bus.load_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", bus.load_ready); tests_failed++; end
    tests_run += 6;
  endtask

  task automatic test_load_fetch();
    logic [63:0] addrs [3] = '{64'd0, 64'd4, 64'd8};
    do_reset();
    load_cycle(1'b1, 32'hF2800020, 1'b0);
    load_cycle(1'b1, 32'hF2800021, 1'b0);
    load_cycle(1'b1, 32'h8B010002, 1'b1);
    if (bus.load_count !== 7'(m_count)) begin $display("FAIL lf_count: got %0d want %0d", bus.load_count, m_count); tests_failed++; end
    if (bus.loaded !== 1'b1) begin $display("FAIL lf_loaded: got %b want 1", bus.loaded); tests_failed++; end
    if (bus.fetch_valid !== 1'b0) begin $display("FAIL lf_idle_valid: got %b want 0", bus.fetch_valid); tests_failed++; end
    tests_run += 3;
    foreach (addrs[i]) begin
      fetch_issue(1'b1, addrs[i]);
      if (bus.fetch_valid !== 1'b1) begin $display("FAIL lf_valid[%0d]: got %b want 1", i, bus.fetch_valid); tests_failed++; end
      if (bus.fetch_instr !== exp_instr(addrs[i])) begin $display("FAIL lf_instr[%0d]: got %h want %h", i, bus.fetch_instr, exp_instr(addrs[i])); tests_failed++; end
      if (bus.fetch_fault !== exp_fault(addrs[i])) begin $display("FAIL lf_fault[%0d]: got %b want %b", i, bus.fetch_fault, exp_fault(addrs[i])); tests_failed++; end
      tests_run += 3;
    end
    fetch_issue(1'b0, 64'd0);
    if (bus.fetch_valid !== 1'b0) begin $display("FAIL lf_end_valid: got %b want 0", bus.fetch_valid); tests_failed++; end
    tests_run++;
  endtask

  task automatic test_faults();
    logic [63:0] addrs [4] = '{64'd12, 64'd6, 64'd256, 64'h102};
    foreach (addrs[i]) begin
      fetch_issue(1'b1, addrs[i]);
      if (bus.fetch_valid !== 1'b1) begin $display("FAIL flt_valid[%0d]: got %b want 1", i, bus.fetch_valid); tests_failed++; end
      if (bus.fetch_instr !== exp_instr(addrs[i])) begin $display("FAIL flt_instr[%0d]: got %h want %h", i, bus.fetch_instr, exp_instr(addrs[i])); tests_failed++; end
      if (bus.fetch_fault !== exp_fault(addrs[i])) begin $display("FAIL flt_fault[%0d]: got %b want %b", i, bus.fetch_fault, exp_fault(addrs[i])); tests_failed++; end
      tests_run += 3;
    end
  endtask

  task automatic test_full_depth();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        if (bus.loaded !== 1'b0) begin $display("FAIL fd_early_run: got %b want 0", bus.loaded); tests_failed++; end
        tests_run++;
      end
      load_cycle(1'b1, 32'(i), 1'b0);
    end
    if (bus.loaded !== 1'b1) begin $display("FAIL fd_loaded: got %b want 1", bus.loaded); tests_failed++; end
    if (bus.load_ready !== 1'b0) begin $display("FAIL fd_ready: got %b want 0", bus.load_ready); tests_failed++; end
    if (bus.load_count !== 7'(m_count)) begin $display("FAIL fd_count: got %0d want %0d", bus.load_count, m_count); tests_failed++; end
    tests_run += 3;
    load_cycle(1'b1, 32'hDEADBEEF, 1'b1);
    if (bus.load_count !== 7'(m_count)) begin $display("FAIL fd_run_ignore: got %0d want %0d", bus.load_count, m_count); tests_failed++; end
    tests_run++;
    fetch_issue(1'b1, 64'd252);
    if (bus.fetch_instr !== exp_instr(64'd252)) begin $display("FAIL fd_instr: got %h want %h", bus.fetch_instr, exp_instr(64'd252)); tests_failed++; end
    if (bus.fetch_fault !== 2'b00) begin $display("FAIL fd_fault: got %b want 00", bus.fetch_fault); tests_failed++; end
    tests_run += 2;
  endtask

  task automatic test_stall();
    logic [63:0] addrs [5] = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd16};
    int c = 0;
    do_reset();
    while (!m_run && c < 20) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 64'd0;
      load_cycle(c % 2 == 0, $urandom, (c % 2 == 0) && (m_count == 3));
      if (bus.fetch_valid !== 1'b0) begin $display("FAIL st_load_fetch[%0d]: got %b want 0", c, bus.fetch_valid); tests_failed++; end
      tests_run++;
      c++;
    end
    bus.fetch_req = 1'b0;
    if (!m_run) begin $display("FAIL st_timeout: got %0d words want 4", m_count); tests_failed++; end
    if (bus.load_count !== 7'd4) begin $display("FAIL st_count: got %0d want 4", bus.load_count); tests_failed++; end
    tests_run += 2;
    foreach (addrs[i]) begin
      fetch_issue(1'b1, addrs[i]);
      if (bus.fetch_instr !== exp_instr(addrs[i])) begin $display("FAIL st_instr[%0d]: got %h want %h", i, bus.fetch_instr, exp_instr(addrs[i])); tests_failed++; end
      tests_run++;
    end
  endtask

  task automatic test_restart();
    fetch_issue(1'b1, 64'd0);
    if (bus.fetch_valid !== 1'b1) begin $display("FAIL rs_pre_valid: got %b want 1", bus.fetch_valid); tests_failed++; end
    tests_run++;
    bus.load_restart = 1'b1;
    fetch_issue(1'b1, 64'd0);
    bus.load_restart = 1'b0;
    model_clear();
    if (bus.fetch_valid !== 1'b0) begin $display("FAIL rs_valid: got %b want 0", bus.fetch_valid); tests_failed++; end
    if (bus.loaded !== 1'b0) begin $display("FAIL rs_loaded: got %b want 0", bus.loaded); tests_failed++; end
    if (bus.load_ready !== 1'b1) begin $display("FAIL rs_ready: got %b want 1", bus.load_ready); tests_failed++; end
    if (bus.load_count !== 7'd0) begin $display("FAIL rs_count: got %0d want 0", bus.load_count); tests_failed++; end
    tests_run += 4;
    load_cycle(1'b1, 32'h8B010002, 1'b1);
    fetch_issue(1'b1, 64'd4);
    if (bus.fetch_instr !== exp_instr(64'd4)) begin $display("FAIL rs_instr4: got %h want %h", bus.fetch_instr, exp_instr(64'd4)); tests_failed++; end
    fetch_issue(1'b1, 64'd0);
    if (bus.fetch_instr !== exp_instr(64'd0)) begin $display("FAIL rs_instr0: got %h want %h", bus.fetch_instr, exp_instr(64'd0)); tests_failed++; end
    tests_run += 2;
  endtask

  task automatic test_reset_midload();
    do_reset();
    load_cycle(1'b1, 32'hF2800020, 1'b0);
    load_cycle(1'b1, 32'h12345678, 1'b0);
    if (bus.load_count !== 7'd2) begin $display("FAIL rm_partial: got %0d want 2", bus.load_count); tests_failed++; end
    tests_run++;
    do_reset();
    if (bus.load_count !== 7'd0) begin $display("FAIL rm_count: got %0d want 0", bus.load_count); tests_failed++; end
    tests_run++;
    load_cycle(1'b1, 32'hF2800021, 1'b1);
    fetch_issue(1'b1, 64'd0);
    if (bus.fetch_instr !== exp_instr(64'd0)) begin $display("FAIL rm_instr0: got %h want %h", bus.fetch_instr, exp_instr(64'd0)); tests_failed++; end
    fetch_issue(1'b1, 64'd4);
    if (bus.fetch_instr !== exp_instr(64'd4)) begin $display("FAIL rm_instr4: got %h want %h", bus.fetch_instr, exp_instr(64'd4)); tests_failed++; end
    tests_run += 2;
  endtask

  task automatic test_random();
    int          n     = $urandom_range(1, DEPTH);
    int          guard = 0;
    logic [31:0] last_instr = NOP;
    logic [1:0]  last_fault = 2'b00;
    do_reset();
    while (!m_run && guard < 400) begin
      bit v = 1'($urandom_range(0, 1));
      load_cycle(v, $urandom, v && (m_count == n - 1));
      guard++;
    end
    if (bus.loaded !== 1'b1) begin $display("FAIL rnd_loaded: got %b want 1", bus.loaded); tests_failed++; end
    tests_run++;
    for (int k = 0; k < 80; k++) begin
      bit          req = ($urandom_range(0, 3) != 0);
      int          sel = $urandom_range(0, 9);
      logic [63:0] a;
      if (sel < 7)       a = 64'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) a = (64'($urandom_range(0, DEPTH - 1)) << 2) | 64'($urandom_range(1, 3));
      else begin
        a = {32'($urandom), 32'($urandom)};
        a[20] = 1'b1;
        if (sel == 8) a[1:0] = 2'b00;
      end
      fetch_issue(req, a);
      if (req) begin
        last_instr = exp_instr(a);
        last_fault = exp_fault(a);
      end
      if (bus.fetch_valid !== req) begin $display("FAIL rnd_valid[%0d]: got %b want %b", k, bus.fetch_valid, req); tests_failed++; end
      if (bus.fetch_instr !== last_instr) begin $display("FAIL rnd_instr[%0d]: got %h want %h", k, bus.fetch_instr, last_instr); tests_failed++; end
      if (bus.fetch_fault !== last_fault) begin $display("FAIL rnd_fault[%0d]: got %b want %b", k, bus.fetch_fault, last_fault); tests_failed++; end
      tests_run += 3;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_fetch();
    test_faults();
    test_full_depth();
    test_stall();
    test_restart();
    test_reset_midload();
    for (int r = 0; r < 4; r++) test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the LEGv8 single-cycle and future pipelined datapath.
- Replaces the fixed combinational Instruction_Memory.
- Adds a streaming program-load port with a valid/ready handshake and a LOAD/RUN state machine.
- Fetch side has one-cycle registered latency, with misalignment and out-of-range fault flags.
- Unwritten or faulted words return a configurable NOP.

Parameters:
- ADDR_WIDTH, 64: width of the byte address driven by the PC.
- DATA_WIDTH, 32: instruction word width.
- DEPTH, 64: number of instruction words; power of two, at least 2.
- IDX_W, $clog2(DEPTH): word index width, derived.
- NOP_WORD, 32'hD503201F: value returned for unwritten or faulted fetches.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- load_valid, input, 1: load_data is valid.
- load_ready, output, 1: loader can accept a word (high only in LOAD).
- load_data, input, DATA_WIDTH: instruction word to store at the write pointer.
- load_last, input, 1: qualifies the final word of a program.
- load_restart, input, 1: in RUN, return to LOAD and begin a new program.
- load_count, output, IDX_W+1: words accepted since the last reset or restart.
- loaded, output, 1: high in RUN.
- fetch_req, input, 1: fetch request, sampled at the clock edge.
- fetch_addr, input, ADDR_WIDTH: byte address of the instruction.
- fetch_valid, output, 1: response valid, exactly one cycle after an accepted request.
- fetch_instr, output, DATA_WIDTH: fetched instruction.
- fetch_fault, output, 2: bit0 = misaligned; bit1 = out of range.

Behaviour:
- Reset (synchronous, active-high, wins over all inputs):
  - state = LOAD; wptr = 0; load_count = 0; the per-word written bitmap is cleared.
  - fetch_valid = 0, fetch_instr = NOP_WORD, fetch_fault = 0, loaded = 0.
  - load_ready goes high in the first cycle after reset deasserts.
  - Memory array contents are not cleared; the bitmap masks them.
- LOAD state:
  - load_ready = 1.
  - A word is accepted when load_valid && load_ready at the edge. It writes mem[wptr] = load_data, sets written[wptr], increments wptr and increments load_count.
  - Transition to RUN after accepting a word with load_last = 1, or after accepting the word at wptr = DEPTH-1, whichever occurs first. load_count saturates at DEPTH.
  - fetch_req is ignored; fetch_valid stays 0.
  - load_restart is ignored.
- RUN state:
  - load_ready = 0; loaded = 1; load_valid is ignored.
  - On an edge with fetch_req = 1 and load_restart = 0, the next cycle drives fetch_valid = 1 for one cycle, plus fetch_instr and fetch_fault.
  - Back-to-back requests produce back-to-back responses, one per cycle, with no bubbles.
- Fault rules:
  - bit0 = (fetch_addr[1:0] != 0).
  - bit1 = (fetch_addr[ADDR_WIDTH-1:2] >= DEPTH).
  - Both bits may be set together.
- Instruction selection:
  - Any fault set: fetch_instr = NOP_WORD.
  - No fault and word unwritten: fetch_instr = NOP_WORD, fetch_fault = 0.
  - Otherwise: fetch_instr = mem[fetch_addr[IDX_W+1:2]].
  - fetch_instr and fetch_fault hold their last values while fetch_valid = 0.
- Restart:
  - load_restart = 1 in RUN moves to LOAD at the next edge, and clears wptr, load_count and the bitmap.
  - If fetch_req is high in the same cycle, restart wins and no response is generated.
  - A response already pending from the previous cycle still completes.
- Reset mid-load discards the partial program: bitmap and count return to 0.
- No combinational path from the fetch inputs to the fetch outputs. Memory is a single write port plus a single read port, so it maps to BRAM/LUTRAM.

Test Plan:
- Load and fetch:
  - Stimulus: reset; stream 0xF2800020, 0xF2800021, 0x8B010002 with load_last on the third; then fetch addresses 0, 4, 8 on consecutive cycles.
  - Required: load_count = 3, loaded = 1; fetch_valid high for 3 cycles starting one cycle after the first request; fetch_instr = 0xF2800020, 0xF2800021, 0x8B010002; fetch_fault = 0.
- Unwritten and faulted fetches, after the 3-word load:
  - fetch 12 -> 0xD503201F, fault = 00.
  - fetch 6 -> NOP, fault = 01.
  - fetch 256 -> NOP, fault = 10.
  - fetch 0x102 -> NOP, fault = 11.
- Full-depth load:
  - Stimulus: DEPTH = 64, 64 words with data = index and load_last never asserted.
  - Required: RUN entered after the 64th accept, load_ready = 0, load_count = 64; fetch 252 -> 0x0000003F.
- Handshake stall:
  - Stimulus: toggle load_valid every other cycle while loading 4 words.
  - Required: only the 4 qualified words are stored, in order; fetch during LOAD gives no fetch_valid.
- Restart collision:
  - Stimulus: in RUN, assert fetch_req(0) and load_restart together.
  - Required: no fetch_valid; state LOAD; load_count = 0; after reloading 1 word (0x8B010002, last), fetch 4 -> NOP.
- Reset mid-load:
  - Stimulus: reset after 2 words are accepted; then load 1 word 0xF2800021 with last.
  - Required: fetch 0 -> 0xF2800021; fetch 4 -> NOP.
